// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding, bus widths and the instr/pc4 pair.
// Pure declarations; no timing or backpressure of its own.
package fetch_pkg;

   localparam int INSTR_W    = 32;
   localparam int ADDR_W     = 32;
   localparam int PC_INC_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc4;
   } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched {instr, pc4} while decode is stalled.
// Loads on the edge after push; pop empties it; flush beats push; a push alongside a pop refills it.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  fetch_word_t din,
   output fetch_word_t dout,
   output logic        full
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         dout <= '0;
      end else if (flush) begin
         full <= 1'b0;
      end else if (push) begin
         full <= 1'b1;
         dout <= din;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, imem ready handshake, registered instruction; 1 edge ready->if_valid, skid absorbs one word under id_stall.
// Optional FETCH_PERF_CNT_EN adds delivered-word and stall-cycle counters.
module instr_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                PC_INC   = PC_INC_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               id_stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc4,
   output logic [15:0]        if_imm16
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_stall_cnt
`endif
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, disc_addr_q, pc_next_seq;
   logic              accept, hold, load_out, valid_d;
   logic              skid_push, skid_pop, skid_full, skid_full_d, issue_ok;
   fetch_word_t       fetched, skid_dout, load_word;

   assign pc_next_seq = pc_q + ADDR_W'(PC_INC);

   always_comb begin
      accept        = (state_q == REQ) && imem_ready && !redirect;
      fetched.instr = imem_rdata;
      fetched.pc4   = pc_next_seq;
      hold          = if_valid && id_stall;
      skid_push     = 1'b0;
      skid_pop      = 1'b0;
      load_out      = 1'b0;
      load_word     = fetched;
      valid_d       = if_valid;
      if (redirect) begin
         valid_d = 1'b0;
      end else if (hold) begin
         skid_push = accept;
      end else if (skid_full) begin
         // Skid is older than any word arriving now, so it goes out first.
         load_out  = 1'b1;
         load_word = skid_dout;
         skid_pop  = 1'b1;
         skid_push = accept;
         valid_d   = 1'b1;
      end else begin
         load_out = accept;
         valid_d  = accept;
      end
      skid_full_d = !redirect && (skid_push || (skid_full && !skid_pop));
      issue_ok    = !skid_full_d && !(valid_d && id_stall);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (issue_ok) state_d = REQ;
         REQ:     if (imem_ready) state_d = issue_ok ? REQ : IDLE;
         DISCARD: if (imem_ready) state_d = REQ;
         default: state_d = REQ;
      endcase
      if (redirect)
         state_d = (state_q != IDLE && !imem_ready) ? DISCARD : REQ;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         disc_addr_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         if (redirect) begin
            pc_q <= redirect_pc & ~ADDR_W'(3);
            if (state_q == REQ)
               disc_addr_q <= pc_q;
         end else if (accept) begin
            pc_q <= pc_next_seq;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc4   <= '0;
         if_imm16 <= '0;
      end else begin
         if_valid <= valid_d;
         if (load_out) begin
            if_instr <= load_word.instr;
            if_pc4   <= load_word.pc4;
            if_imm16 <= load_word.instr[15:0];
         end
      end
   end

   // DISCARD keeps presenting the pre-redirect address until its response lands.
   assign imem_req  = !rst && (state_q != IDLE);
   assign imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;

   fetch_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (skid_push),
      .pop   (skid_pop),
      .flush (redirect),
      .din   (fetched),
      .dout  (skid_dout),
      .full  (skid_full)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (load_out) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (hold)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
